ex_stage_mdu: RTL

Parametrised execute stage with an integrated EX/MEM pipeline register and an iterative multiplier. It sits between the ID/EX register and the memory stage. It widens the ALU op set and adds a multi-cycle MUL with a valid/ready handshake. It adds stall and flush handling and bubble injection, and drives a busy signal to the hazard unit.

---
 rtl/ex_pkg.sv | 19 +
 rtl/ex_mul_seq.sv | 44 ++++
 rtl/ex_stage_mdu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op encodings and FSM states.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, XLEN steps.
module ex_mul_seq #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic [CW-1:0]   cnt
);

  logic [XLEN-1:0] mcand, mplier, acc;

  // done is high during the cycle whose closing edge performs the final step
  assign done    = (cnt == CW'(1));
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(XLEN);
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage with EX/MEM register, multi-cycle MUL, stall/flush and bubble handling.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int WBW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic            alu_src,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] npc,
  input  logic [REGW-1:0] rd,
  input  logic            reg_wr,
  input  logic            mem_wr,
  input  logic            mem_rd,
  input  logic [WBW-1:0]  wb_sel,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] store_d,
  output logic [XLEN-1:0] npc_out,
  output logic [REGW-1:0] rd_out,
  output logic            reg_wr_out,
  output logic            mem_wr_out,
  output logic            mem_rd_out,
  output logic [WBW-1:0]  wb_sel_out
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  ex_state_e       state;
  logic [XLEN-1:0] bop, alu_res, mul_prod;
  logic [SHW-1:0]  shamt;
  logic [CW-1:0]   mul_cnt;
  logic            accept, mul_start, mul_done;

  // fields of the MUL instruction, held until the product retires
  logic [XLEN-1:0] l_npc, l_store;
  logic [REGW-1:0] l_rd;
  logic [WBW-1:0]  l_wb_sel;
  logic            l_reg_wr, l_mem_wr, l_mem_rd;

  assign in_ready  = (state == IDLE) & ~mem_stall;
  assign accept    = in_valid & in_ready & ~flush;
  assign mul_start = accept & (alu_op == ALU_MUL);
  assign busy      = (state != IDLE);
  assign bop       = alu_src ? imm : b;
  assign shamt     = bop[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = a + bop;
      ALU_SUB:  alu_res = a - bop;
      ALU_OR:   alu_res = a | bop;
      ALU_NOR:  alu_res = ~(a | bop);
      ALU_AND:  alu_res = a & bop;
      ALU_XOR:  alu_res = a ^ bop;
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(bop)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < bop};
      default:  alu_res = '0;
    endcase
  end

  ex_mul_seq #(.XLEN(XLEN), .CW(CW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (a),
    .b       (bop),
    .done    (mul_done),
    .product (mul_prod),
    .cnt     (mul_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mul_start) state <= MUL;
        MUL:     if (mul_done) state <= DONE;
        DONE:    if (!mem_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_npc    <= '0;
      l_store  <= '0;
      l_rd     <= '0;
      l_wb_sel <= '0;
      l_reg_wr <= 1'b0;
      l_mem_wr <= 1'b0;
      l_mem_rd <= 1'b0;
    end else if (mul_start) begin
      l_npc    <= npc;
      l_store  <= b;
      l_rd     <= rd;
      l_wb_sel <= wb_sel;
      l_reg_wr <= reg_wr;
      l_mem_wr <= mem_wr;
      l_mem_rd <= mem_rd;
    end
  end

  // EX/MEM register: flush beats stall, stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      reg_wr_out <= 1'b0;
      mem_wr_out <= 1'b0;
      mem_rd_out <= 1'b0;
      alu_out    <= '0;
      store_d    <= '0;
      npc_out    <= '0;
      rd_out     <= '0;
      wb_sel_out <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      reg_wr_out <= 1'b0;
      mem_wr_out <= 1'b0;
      mem_rd_out <= 1'b0;
    end else if (!mem_stall) begin
      if (state == DONE) begin
        out_valid  <= 1'b1;
        alu_out    <= mul_prod;
        store_d    <= l_store;
        npc_out    <= l_npc;
        rd_out     <= l_rd;
        wb_sel_out <= l_wb_sel;
        reg_wr_out <= l_reg_wr;
        mem_wr_out <= l_mem_wr;
        mem_rd_out <= l_mem_rd;
      end else if (accept && !mul_start) begin
        out_valid  <= 1'b1;
        alu_out    <= alu_res;
        store_d    <= b;
        npc_out    <= npc;
        rd_out     <= rd;
        wb_sel_out <= wb_sel;
        reg_wr_out <= reg_wr;
        mem_wr_out <= mem_wr;
        mem_rd_out <= mem_rd;
      end else begin
        out_valid  <= 1'b0;
        reg_wr_out <= 1'b0;
        mem_wr_out <= 1'b0;
        mem_rd_out <= 1'b0;
      end
    end
  end

endmodule
